// File: rtl/sdram_ctrl_2m32.sv
// Single-access SDRAM controller for a 2M x 32 part (4 banks x 2048 rows x 256 columns).
// Every access uses auto-precharge at CAS latency 2; auto refresh has priority over requests.
module sdram_ctrl_2m32 #(
    parameter int unsigned T_INIT = 20000,
    parameter int unsigned T_REFI = 1500,
    parameter int unsigned T_RP   = 2,
    parameter int unsigned T_RCD  = 2,
    parameter int unsigned T_RFC  = 7,
    parameter int unsigned T_WR   = 2,
    parameter int unsigned T_MRD  = 2
) (
    input  logic        MainClk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [20:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        init_done,
    output logic [10:0] sdram_ADDR,
    output logic [1:0]  sdram_BA,
    output logic        sdram_CSn,
    output logic        sdram_RASn,
    output logic        sdram_CASn,
    output logic        sdram_WEn,
    output logic        sdram_CKE,
    output logic [3:0]  sdram_DQM,
    input  logic [31:0] sdram_DQ_read,
    output logic [31:0] sdram_DQ_write,
    output logic [31:0] sdram_DQ_writeEnable
);

    localparam int unsigned CW = 16;

    // {CSn, RASn, CASn, WEn}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACT     = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_REF1,
        INIT_REF2,
        INIT_MRS,
        IDLE,
        REFRESH,
        ACT,
        RW,
        PRE_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   ref_cnt_q, ref_cnt_d;
    logic            ref_pend_q, ref_pend_d;
    logic            init_done_q, init_done_d;

    logic            req_write_q, req_write_d;
    logic [1:0]      req_ba_q, req_ba_d;
    logic [7:0]      req_col_q, req_col_d;
    logic [31:0]     req_wdata_q, req_wdata_d;
    logic [3:0]      req_mask_q, req_mask_d;

    logic [3:0]      cmd_q, cmd_d;
    logic [10:0]     addr_q, addr_d;
    logic [1:0]      ba_q, ba_d;
    logic [3:0]      dqm_q, dqm_d;
    logic [31:0]     dq_out_q, dq_out_d;
    logic [31:0]     dq_oe_q, dq_oe_d;
    logic            cke_q;

    logic [1:0]      rd_pipe_q, rd_pipe_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_cnt_d   = ref_cnt_q;
        ref_pend_d  = ref_pend_q;
        init_done_d = init_done_q;
        req_write_d = req_write_q;
        req_ba_d    = req_ba_q;
        req_col_d   = req_col_q;
        req_wdata_d = req_wdata_q;
        req_mask_d  = req_mask_q;
        cmd_d       = CMD_NOP;
        addr_d      = '0;
        ba_d        = '0;
        dqm_d       = 4'hF;
        dq_out_d    = '0;
        dq_oe_d     = '0;

        // A re-expiry while still pending simply leaves the flag set.
        if (init_done_q) begin
            if (ref_cnt_q == '0) begin
                ref_cnt_d  = CW'(T_REFI - 1);
                ref_pend_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q - 1'b1;
            end
        end

        unique case (state_q)
            INIT_WAIT: begin
                if (cnt_q == CW'(T_INIT - 1)) begin
                    cmd_d      = CMD_PRE;
                    addr_d[10] = 1'b1;
                    cnt_d      = CW'(T_RP - 1);
                    state_d    = INIT_PRE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            INIT_PRE: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    cnt_d   = CW'(T_RFC - 1);
                    state_d = INIT_REF1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            INIT_REF1: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_REF;
                    cnt_d   = CW'(T_RFC - 1);
                    state_d = INIT_REF2;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            INIT_REF2: begin
                if (cnt_q == '0) begin
                    cmd_d   = CMD_MRS;
                    addr_d  = 11'h020;  // burst length 1, sequential, CAS latency 2
                    cnt_d   = CW'(T_MRD - 1);
                    state_d = INIT_MRS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            INIT_MRS: begin
                if (cnt_q == '0) begin
                    init_done_d = 1'b1;
                    ref_cnt_d   = CW'(T_REFI - 1);
                    ref_pend_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (ref_pend_q) begin
                    cmd_d      = CMD_REF;
                    ref_pend_d = (ref_cnt_q == '0);
                    cnt_d      = CW'(T_RFC - 1);
                    state_d    = REFRESH;
                end else if (cmd_valid) begin
                    req_write_d = cmd_write;
                    req_ba_d    = cmd_addr[20:19];
                    req_col_d   = cmd_addr[7:0];
                    req_wdata_d = cmd_wdata;
                    req_mask_d  = cmd_mask;
                    cmd_d       = CMD_ACT;
                    ba_d        = cmd_addr[20:19];
                    addr_d      = cmd_addr[18:8];
                    cnt_d       = CW'(T_RCD - 1);
                    state_d     = ACT;
                end
            end
            REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACT: begin
                if (cnt_q == '0) begin
                    ba_d    = req_ba_q;
                    addr_d  = {1'b1, 2'b00, req_col_q};
                    state_d = RW;
                    if (req_write_q) begin
                        cmd_d    = CMD_WRITE;
                        dqm_d    = ~req_mask_q;
                        dq_out_d = req_wdata_q;
                        dq_oe_d  = '1;
                        cnt_d    = CW'(T_WR - 1);
                    end else begin
                        cmd_d = CMD_READ;
                        dqm_d = 4'h0;
                        cnt_d = CW'(2);  // hold off precharge wait until read data is back
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RW: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(T_RP - 1);
                    state_d = PRE_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PRE_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = INIT_WAIT;
            end
        endcase
    end

    // Read data returns two cycles after the READ is on the pins.
    always_comb begin
        rd_pipe_d   = {rd_pipe_q[0], cmd_q == CMD_READ};
        rsp_valid_d = rd_pipe_q[1];
        rsp_data_d  = rd_pipe_q[1] ? sdram_DQ_read : rsp_data_q;
    end

    always_ff @(posedge MainClk) begin
        if (Reset) begin
            state_q     <= INIT_WAIT;
            cnt_q       <= '0;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
            init_done_q <= 1'b0;
            req_write_q <= 1'b0;
            req_ba_q    <= '0;
            req_col_q   <= '0;
            req_wdata_q <= '0;
            req_mask_q  <= '0;
            cmd_q       <= CMD_INHIBIT;
            addr_q      <= '0;
            ba_q        <= '0;
            dqm_q       <= 4'hF;
            dq_out_q    <= '0;
            dq_oe_q     <= '0;
            cke_q       <= 1'b0;
            rd_pipe_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            init_done_q <= init_done_d;
            req_write_q <= req_write_d;
            req_ba_q    <= req_ba_d;
            req_col_q   <= req_col_d;
            req_wdata_q <= req_wdata_d;
            req_mask_q  <= req_mask_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            dqm_q       <= dqm_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            cke_q       <= 1'b1;
            rd_pipe_q   <= rd_pipe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !ref_pend_q;
    assign init_done = init_done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    assign {sdram_CSn, sdram_RASn, sdram_CASn, sdram_WEn} = cmd_q;
    assign sdram_ADDR           = addr_q;
    assign sdram_BA             = ba_q;
    assign sdram_CKE            = cke_q;
    assign sdram_DQM            = dqm_q;
    assign sdram_DQ_write       = dq_out_q;
    assign sdram_DQ_writeEnable = dq_oe_q;

endmodule

// File: tb/tb_sdram_ctrl_2m32.sv
// Directed bench for sdram_ctrl_2m32: init sequence, write, read, refresh priority, reset abort.
module tb_sdram_ctrl_2m32;

    localparam logic [3:0] INHIBIT = 4'b1111;
    localparam logic [3:0] NOP     = 4'b0111;
    localparam logic [3:0] ACT     = 4'b0011;
    localparam logic [3:0] RD      = 4'b0101;
    localparam logic [3:0] WR      = 4'b0100;
    localparam logic [3:0] PRE     = 4'b0010;
    localparam logic [3:0] REF     = 4'b0001;
    localparam logic [3:0] MRS     = 4'b0000;

    logic        MainClk = 1'b0;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [20:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;
    logic [10:0] sdram_ADDR;
    logic [1:0]  sdram_BA;
    logic        sdram_CSn, sdram_RASn, sdram_CASn, sdram_WEn, sdram_CKE;
    logic [3:0]  sdram_DQM;
    logic [31:0] sdram_DQ_read;
    logic [31:0] sdram_DQ_write;
    logic [31:0] sdram_DQ_writeEnable;
    logic [3:0]  cmd;

    int cyc;
    int n_tests;
    int n_fail;

    assign cmd = {sdram_CSn, sdram_RASn, sdram_CASn, sdram_WEn};

    always #5 MainClk = ~MainClk;

    sdram_ctrl_2m32 #(
        .T_INIT(100),
        .T_REFI(200)
    ) dut (
        .MainClk              (MainClk),
        .Reset                (Reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_addr             (cmd_addr),
        .cmd_wdata            (cmd_wdata),
        .cmd_mask             (cmd_mask),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .init_done            (init_done),
        .sdram_ADDR           (sdram_ADDR),
        .sdram_BA             (sdram_BA),
        .sdram_CSn            (sdram_CSn),
        .sdram_RASn           (sdram_RASn),
        .sdram_CASn           (sdram_CASn),
        .sdram_WEn            (sdram_WEn),
        .sdram_CKE            (sdram_CKE),
        .sdram_DQM            (sdram_DQM),
        .sdram_DQ_read        (sdram_DQ_read),
        .sdram_DQ_write       (sdram_DQ_write),
        .sdram_DQ_writeEnable (sdram_DQ_writeEnable)
    );

    task automatic step();
        @(posedge MainClk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, 32'(cmd), 32'(INHIBIT));
        check({tag, "_cke"}, 32'(sdram_CKE), 32'h0);
        check({tag, "_addr"}, 32'(sdram_ADDR), 32'h0);
        check({tag, "_ba"}, 32'(sdram_BA), 32'h0);
        check({tag, "_dqm"}, 32'(sdram_DQM), 32'hF);
        check({tag, "_dq_oe"}, sdram_DQ_writeEnable, 32'h0);
        check({tag, "_dq_out"}, sdram_DQ_write, 32'h0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
        check({tag, "_init_done"}, 32'(init_done), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        Reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_mask = '0;
        sdram_DQ_read = '0;
        repeat (3) @(posedge MainClk);
        #1;
        check_reset_outputs("reset");

        // Release reset; the next edge ends cycle 0. Hold a write request through init.
        Reset = 1'b0;
        cyc = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 21'h00A5F3;
        cmd_wdata = 32'hDEADBEEF;
        cmd_mask = 4'b0101;
        for (int c = 1; c < 100; c++) begin
            step();
            check("init_nop_not_ready", {27'h0, cmd_ready, cmd}, {27'h0, 1'b0, NOP});
        end
        check("init_cke", 32'(sdram_CKE), 32'h1);
        step();
        check("init_pre", 32'(cmd), 32'(PRE));
        check("init_pre_a10", 32'(sdram_ADDR[10]), 32'h1);
        step();
        check("init_nop_after_pre", 32'(cmd), 32'(NOP));
        run_to(102);
        check("init_ref1", 32'(cmd), 32'(REF));
        run_to(108);
        check("init_nop_before_ref2", 32'(cmd), 32'(NOP));
        run_to(109);
        check("init_ref2", 32'(cmd), 32'(REF));
        run_to(116);
        check("init_mrs", 32'(cmd), 32'(MRS));
        check("init_mrs_addr", 32'(sdram_ADDR), 32'h020);
        check("init_mrs_ba", 32'(sdram_BA), 32'h0);
        step();
        check("init_done_early", 32'(init_done), 32'h0);
        check("ready_early", 32'(cmd_ready), 32'h0);
        step();
        check("init_done", 32'(init_done), 32'h1);
        check("ready_after_init", 32'(cmd_ready), 32'h1);

        // Write accepted at cycle 118.
        step();
        cmd_valid = 1'b0;
        check("wr_act", 32'(cmd), 32'(ACT));
        check("wr_act_ba", 32'(sdram_BA), 32'h0);
        check("wr_act_row", 32'(sdram_ADDR), 32'h0A5);
        check("wr_busy", 32'(cmd_ready), 32'h0);
        step();
        check("wr_gap_nop", 32'(cmd), 32'(NOP));
        check("wr_gap_oe", sdram_DQ_writeEnable, 32'h0);
        step();
        check("wr_cmd", 32'(cmd), 32'(WR));
        check("wr_addr", 32'(sdram_ADDR), 32'h4F3);
        check("wr_dqm", 32'(sdram_DQM), 32'hA);
        check("wr_oe", sdram_DQ_writeEnable, 32'hFFFFFFFF);
        check("wr_data", sdram_DQ_write, 32'hDEADBEEF);
        step();
        check("wr_after_oe", sdram_DQ_writeEnable, 32'h0);
        check("wr_after_dqm", 32'(sdram_DQM), 32'hF);
        check("wr_after_cmd", 32'(cmd), 32'(NOP));
        run_to(124);
        check("wr_recovery_busy", 32'(cmd_ready), 32'h0);
        step();
        check("wr_idle", 32'(cmd_ready), 32'h1);

        // Read accepted at cycle 125; READ at 128, data driven during 130.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("rd_act", 32'(cmd), 32'(ACT));
        check("rd_act_row", 32'(sdram_ADDR), 32'h0A5);
        run_to(128);
        check("rd_cmd", 32'(cmd), 32'(RD));
        check("rd_addr", 32'(sdram_ADDR), 32'h4F3);
        check("rd_dqm", 32'(sdram_DQM), 32'h0);
        check("rd_oe", sdram_DQ_writeEnable, 32'h0);
        step();
        check("rd_dqm_after", 32'(sdram_DQM), 32'hF);
        step();
        sdram_DQ_read = 32'h12345678;
        check("rd_no_early_valid", 32'(rsp_valid), 32'h0);
        step();
        sdram_DQ_read = 32'h0;
        check("rd_valid", 32'(rsp_valid), 32'h1);
        check("rd_data", rsp_data, 32'h12345678);
        step();
        check("rd_single_pulse", 32'(rsp_valid), 32'h0);
        check("rd_precharge_busy", 32'(cmd_ready), 32'h0);
        step();
        check("rd_idle", 32'(cmd_ready), 32'h1);

        // Refresh counter expires at 317; pending visible from 318.
        run_to(317);
        check("ref_not_yet", 32'(cmd_ready), 32'h1);
        step();
        check("ref_pending_blocks", 32'(cmd_ready), 32'h0);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 21'h112345;
        step();
        check("ref_cmd", 32'(cmd), 32'(REF));
        for (int c = 319; c < 326; c++) begin
            check("ref_busy", 32'(cmd_ready), 32'h0);
            check("ref_no_act", 32'(cmd == ACT), 32'h0);
            step();
        end
        check("ref_done_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        check("ref_req_act", 32'(cmd), 32'(ACT));
        check("ref_req_ba", 32'(sdram_BA), 32'h2);
        check("ref_req_row", 32'(sdram_ADDR), 32'h123);
        run_to(329);
        check("ref_req_read", 32'(cmd), 32'(RD));
        check("ref_req_addr", 32'(sdram_ADDR), 32'h445);

        // Reset one cycle after the READ: the pending response must be dropped.
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_reset_outputs("abort");
        sdram_DQ_read = 32'hCAFEF00D;
        cyc = 0;
        step();
        check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        check("abort_cke", 32'(sdram_CKE), 32'h1);
        check("abort_nop", 32'(cmd), 32'(NOP));
        step();
        check("abort_no_rsp_late", 32'(rsp_valid), 32'h0);
        run_to(99);
        check("reinit_nop", 32'(cmd), 32'(NOP));
        step();
        check("reinit_pre", 32'(cmd), 32'(PRE));
        check("reinit_pre_a10", 32'(sdram_ADDR[10]), 32'h1);
        run_to(117);
        check("reinit_not_done", 32'(init_done), 32'h0);
        step();
        check("reinit_done", 32'(init_done), 32'h1);
        check("reinit_ready", 32'(cmd_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_ctrl_2m32.md
SDRAM_CTRL_2M32 -- requirements
Module: sdram_ctrl_2m32

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- T_INIT, 20000, power-up NOP wait in cycles.
- T_REFI, 1500, refresh interval in cycles.
- T_RP, 2, precharge time.
- T_RCD, 2, ACTIVATE to READ/WRITE delay.
- T_RFC, 7, refresh cycle time.
- T_WR, 2, write recovery.
- T_MRD, 2, MRS to next command.
- CAS latency fixed at 2.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; ports (name, direction, width, meaning):
- MainClk, in, 1, clock.
- Reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, request valid.
- cmd_ready, out, 1, request accepted when valid & ready.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, 21, word address {bank[1:0], row[10:0], col[7:0]}.
- cmd_wdata, in, 32, write data.
- cmd_mask, in, 4, byte enables.
- rsp_valid, out, 1, one-cycle read data strobe.
- rsp_data, out, 32, read data.
- init_done, out, 1, initialisation complete.
- sdram_ADDR, out, 11; sdram_BA, out, 2; sdram_CSn, sdram_RASn, sdram_CASn, sdram_WEn, sdram_CKE, out, 1 each; sdram_DQM, out, 4.
- sdram_DQ_read, in, 32; sdram_DQ_write, out, 32; sdram_DQ_writeEnable, out, 32, per-bit tristate enables.
REQ-003 All sdram_* outputs and rsp_* outputs SHALL be registered.

Function
REQ-004 The FSM states SHALL be INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REFRESH, ACT, RW, PRE_WAIT.
REQ-005 INIT sequence: INIT_WAIT holds CKE=1 and NOP for T_INIT cycles, then PRECHARGE ALL (ADDR[10]=1) with T_RP wait, then AUTO REFRESH twice with T_RFC wait each, then MRS with ADDR=0x020 and BA=0 (BL1, sequential, CL2), T_MRD wait, then IDLE with init_done=1.
REQ-006 Command encodings {CSn,RASn,CASn,WEn} SHALL be: NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000; all non-command cycles SHALL be NOP.
REQ-007 A refresh counter SHALL reload with T_REFI-1 on entering IDLE from INIT_MRS and decrement every cycle; at 0 it SHALL set refresh_pending and reload. Pending clears when REF is issued; a re-expiry while pending leaves it set (no counting of missed refreshes).
REQ-008 cmd_ready SHALL equal (state==IDLE && !refresh_pending); refresh has strict priority over requests.
REQ-009 In IDLE with refresh_pending, the block SHALL issue REF next cycle, wait T_RFC cycles, then return to IDLE.
REQ-010 Handshake at cycle h SHALL latch the address, data and mask, and issue ACT (BA=bank, ADDR=row) at h+1, then READ/WRITE with auto-precharge (ADDR[10]=1, ADDR[7:0]=col, ADDR[9:8]=0) at h+1+T_RCD.
REQ-011 Write cycle: sdram_DQ_write=wdata, DQ_writeEnable=all ones, DQM=~mask, only during the WRITE cycle; otherwise writeEnable=0 and DQM=4'hF, except DQM=0 during a READ cycle.
REQ-012 A READ at cycle c SHALL sample sdram_DQ_read at the end of c+2 and assert rsp_valid with rsp_data for exactly cycle c+3.
REQ-013 Return to IDLE: after READ at c, IDLE (cmd_ready possible) at c+3+T_RP; after WRITE at c, at c+T_WR+T_RP.
REQ-014 Back-to-back valid requests SHALL be served strictly in order, one at a time; cmd_* SHALL be ignored while cmd_ready=0.
REQ-015 cmd_valid held high during INIT SHALL NOT be accepted until init_done=1.

Reset
REQ-016 Reset SHALL force state=INIT_WAIT, CKE=0, CSn=RASn=CASn=WEn=1, ADDR=0, BA=0, DQM=4'hF, DQ_writeEnable=0, DQ_write=0, cmd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, refresh_pending=0, and all counters=0.
REQ-017 Reset asserted mid-access or mid-refresh SHALL abort it with no rsp_valid and restart the full INIT sequence.

Verification (T_INIT=100, T_REFI=200, other parameters at defaults)
REQ-018 Release reset -> NOP until cycle 100, then PRE(A10=1), REF, REF, MRS(0x020), init_done=1; exact cycle spacing per REQ-005.
REQ-019 Write addr 0x0A5F3 (bank0, row 0x0A5, col 0xF3), data 0xDEADBEEF, mask 4'b0101 -> ACT row 0x0A5, WRITE ADDR=0x4F3, DQM=4'b1010, writeEnable=0xFFFFFFFF for one cycle.
REQ-020 Read the same address with a memory model returning 0x12345678 -> rsp_valid exactly 3 cycles after READ, rsp_data=0x12345678, single pulse.
REQ-021 Refresh expiry coinciding with cmd_valid -> REF issued first, cmd_ready low until T_RFC elapses, then the request is accepted.
REQ-022 Reset asserted 1 cycle after a READ command -> no rsp_valid, all outputs at reset values next cycle, init restarts.
